// File: rtl/fifo_ptr_cnt.sv
// Wrapping pointer counter for the FIFO controller.
// It advances on inc, wraps from Size-1 to 0 and flags the last address.
module fifo_ptr_cnt #(
  parameter int Width = 4,
  parameter int Size  = 16
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             inc,
  output logic [Width-1:0] addr,
  output logic             last
);

  localparam logic [Width-1:0] LastAddr = Width'(Size - 1);

  logic [Width-1:0] addr_reg;
  logic [Width-1:0] addr_next;

  // An explicit compare handles sizes that are not a power of two
  always_comb begin
    addr_next = addr_reg;
    if (inc) begin
      addr_next = (addr_reg == LastAddr) ? '0 : addr_reg + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      addr_reg <= '0;
    end else begin
      addr_reg <= addr_next;
    end
  end

  assign addr = addr_reg;
  assign last = (addr_reg == LastAddr);

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO pointer controller: accepts push/pop requests, drives the RAM pointers
// and keeps occupancy, almost-full and sticky error flags.
module fifo_ptr_ctrl #(
  parameter int BufferWidth     = 4,
  parameter int BufferSize      = 16,
  parameter int AlmostFullLevel = 12
) (
  input  logic                   clk,
  input  logic                   aclr,
  input  logic                   clk_en,
  input  logic                   Push_Req,
  input  logic                   Pop_Req,
  output logic                   Push,
  output logic                   Pop,
  output logic [BufferWidth-1:0] W_Addr,
  output logic [BufferWidth-1:0] R_Addr,
  output logic                   Full,
  output logic                   Empty,
  output logic                   AlmostFull,
  output logic [BufferWidth:0]   Count,
  output logic                   Overflow,
  output logic                   Underflow
);

  localparam logic [BufferWidth:0] AfLevel = (BufferWidth + 1)'(AlmostFullLevel);

  logic                 w_last;
  logic                 r_last;
  logic                 same_addr;
  logic                 round_reg, round_next;
  logic [BufferWidth:0] count_reg, count_next;
  logic                 almost_full_reg, almost_full_next;
  logic                 overflow_reg, overflow_next;
  logic                 underflow_reg, underflow_next;

  fifo_ptr_cnt #(
    .Width (BufferWidth),
    .Size  (BufferSize)
  ) u_wr_ptr (
    .clk  (clk),
    .aclr (aclr),
    .inc  (Push),
    .addr (W_Addr),
    .last (w_last)
  );

  fifo_ptr_cnt #(
    .Width (BufferWidth),
    .Size  (BufferSize)
  ) u_rd_ptr (
    .clk  (clk),
    .aclr (aclr),
    .inc  (Pop),
    .addr (R_Addr),
    .last (r_last)
  );

  // Flags come from registered state only, so requests never loop back into them
  assign same_addr = (W_Addr == R_Addr);
  assign Full      = round_reg & same_addr;
  assign Empty     = ~round_reg & same_addr;

  assign Push = Push_Req & clk_en & ~Full & ~aclr;
  assign Pop  = Pop_Req & clk_en & ~Empty & ~aclr;

  always_comb begin
    round_next       = round_reg;
    count_next       = count_reg;
    overflow_next    = overflow_reg;
    underflow_next   = underflow_reg;
    // The write wrap wins when both pointers wrap in the same cycle
    if (Push && w_last) begin
      round_next = 1'b1;
    end else if (Pop && r_last) begin
      round_next = 1'b0;
    end
    if (Push && !Pop) begin
      count_next = count_reg + (BufferWidth + 1)'(1);
    end else if (Pop && !Push) begin
      count_next = count_reg - (BufferWidth + 1)'(1);
    end
    if (Push_Req && clk_en && Full) begin
      overflow_next = 1'b1;
    end
    if (Pop_Req && clk_en && Empty) begin
      underflow_next = 1'b1;
    end
    almost_full_next = (count_next >= AfLevel);
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      round_reg       <= 1'b0;
      count_reg       <= '0;
      almost_full_reg <= 1'b0;
      overflow_reg    <= 1'b0;
      underflow_reg   <= 1'b0;
    end else if (clk_en) begin
      round_reg       <= round_next;
      count_reg       <= count_next;
      almost_full_reg <= almost_full_next;
      overflow_reg    <= overflow_next;
      underflow_reg   <= underflow_next;
    end
  end

  assign Count      = count_reg;
  assign AlmostFull = almost_full_reg;
  assign Overflow   = overflow_reg;
  assign Underflow  = underflow_reg;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl with BufferSize=16 and AlmostFullLevel=12.
module tb_fifo_ptr_ctrl;

  logic       clk = 1'b0;
  logic       aclr;
  logic       clk_en;
  logic       Push_Req;
  logic       Pop_Req;
  logic       Push;
  logic       Pop;
  logic [3:0] W_Addr;
  logic [3:0] R_Addr;
  logic       Full;
  logic       Empty;
  logic       AlmostFull;
  logic [4:0] Count;
  logic       Overflow;
  logic       Underflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_ptr_ctrl #(
    .BufferWidth     (4),
    .BufferSize      (16),
    .AlmostFullLevel (12)
  ) dut (
    .clk        (clk),
    .aclr       (aclr),
    .clk_en     (clk_en),
    .Push_Req   (Push_Req),
    .Pop_Req    (Pop_Req),
    .Push       (Push),
    .Pop        (Pop),
    .W_Addr     (W_Addr),
    .R_Addr     (R_Addr),
    .Full       (Full),
    .Empty      (Empty),
    .AlmostFull (AlmostFull),
    .Count      (Count),
    .Overflow   (Overflow),
    .Underflow  (Underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply inputs, then let combinational strobes settle before checking
  task automatic drive(input logic rst, input logic en, input logic pu, input logic po);
    aclr     = rst;
    clk_en   = en;
    Push_Req = pu;
    Pop_Req  = po;
    #1;
  endtask

  task automatic check_state(input string tag, input int cnt, input int wa, input int ra,
                             input logic fu, input logic em, input logic af,
                             input logic ov, input logic un);
    check({tag, ".count"}, 32'(Count), 32'(cnt));
    check({tag, ".waddr"}, 32'(W_Addr), 32'(wa));
    check({tag, ".raddr"}, 32'(R_Addr), 32'(ra));
    check({tag, ".full"}, 32'(Full), 32'(fu));
    check({tag, ".empty"}, 32'(Empty), 32'(em));
    check({tag, ".afull"}, 32'(AlmostFull), 32'(af));
    check({tag, ".ovf"}, 32'(Overflow), 32'(ov));
    check({tag, ".unf"}, 32'(Underflow), 32'(un));
    $display("%s: count=%0d w=%0d r=%0d full=%0b empty=%0b af=%0b ovf=%0b unf=%0b",
             tag, Count, W_Addr, R_Addr, Full, Empty, AlmostFull, Overflow, Underflow);
  endtask

  initial begin
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_push_low", 32'(Push), 32'd0);
    check("rst_pop_low", 32'(Pop), 32'd0);
    tick();
    check_state("reset", 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Pop on empty: refused, underflow sticks
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    check("unf_pop", 32'(Pop), 32'd0);
    tick();
    check_state("underflow", 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_state("reset2", 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Fill: sixteen accepted pushes, write pointer wraps 15 -> 0
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      check($sformatf("fill%0d_push", i), 32'(Push), 32'd1);
      tick();
      check_state($sformatf("fill%0d", i), i, i % 16, 0, (i == 16), 1'b0, (i >= 12), 1'b0, 1'b0);
    end

    // Seventeenth push while full
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    check("ovf_push", 32'(Push), 32'd0);
    tick();
    check_state("overflow", 16, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Both requests while full: only the pop is taken
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    check("full_both_push", 32'(Push), 32'd0);
    check("full_both_pop", 32'(Pop), 32'd1);
    tick();
    check_state("full_both", 15, 0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    drive(1'b0, 1'b1, 1'b1, 1'b1);
    check("mid_both_push", 32'(Push), 32'd1);
    check("mid_both_pop", 32'(Pop), 32'd1);
    tick();
    check_state("mid_both", 15, 1, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Disabled clock enable freezes everything
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      check($sformatf("hold%0d_push", i), 32'(Push), 32'd0);
      check($sformatf("hold%0d_pop", i), 32'(Pop), 32'd0);
      tick();
      check_state($sformatf("hold%0d", i), 15, 1, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    end

    // Drain fifteen entries; read pointer wraps 15 -> 0 on the way
    for (int i = 1; i <= 15; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      check($sformatf("drain%0d_pop", i), 32'(Pop), 32'd1);
      tick();
      check_state($sformatf("drain%0d", i), 15 - i, 1, (2 + i) % 16, 1'b0, (i == 15),
                  ((15 - i) >= 12), 1'b1, 1'b0);
    end

    // Both requests while empty: only the push is taken, no fall-through
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    check("empty_both_push", 32'(Push), 32'd1);
    check("empty_both_pop", 32'(Pop), 32'd0);
    tick();
    check_state("empty_both", 1, 2, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Pop is legal the following cycle
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    check("after_empty_pop", 32'(Pop), 32'd1);
    tick();
    check_state("after_empty", 0, 2, 2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Build up to nine entries, then reset in the middle of traffic
    for (int i = 1; i <= 9; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
    end
    check_state("pre_clr", 9, 11, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("clr_push_low", 32'(Push), 32'd0);
    check("clr_pop_low", 32'(Pop), 32'd0);
    tick();
    check_state("mid_clr", 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ptr_ctrl.md
FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

Interface
REQ-001 SHALL have parameter BufferWidth, default 4, meaning the address width of the circular buffer.
REQ-002 SHALL have parameter BufferSize, default 16, meaning the number of entries (legal range 2..2^BufferWidth).
REQ-003 SHALL have parameter AlmostFullLevel, default 12, meaning the occupancy at or above which AlmostFull asserts.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port aclr, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port clk_en, input, 1 bit: global enable; when low, no state changes and Push/Pop are low.
REQ-007 SHALL have ports Push_Req and Pop_Req, each input, 1 bit: write and read requests from the producer and the consumer.
REQ-008 SHALL have ports Push and Pop, each output, 1 bit: accepted-write and accepted-read strobes for the buffer RAM and the wrap-flag logic.
REQ-009 SHALL have ports W_Addr and R_Addr, each output, BufferWidth bits: write and read pointers.
REQ-010 SHALL have ports Full, Empty and AlmostFull, each output, 1 bit: occupancy flags.
REQ-011 SHALL have port Count, output, BufferWidth+1 bits: occupancy, range 0..BufferSize.
REQ-012 SHALL have ports Overflow and Underflow, each output, 1 bit: sticky error flags.

Function
REQ-013 SHALL drive Push as Push_Req & clk_en & ~Full, combinationally in the same cycle.
REQ-014 SHALL drive Pop as Pop_Req & clk_en & ~Empty, combinationally in the same cycle.
REQ-015 SHALL increment W_Addr on each Push, wrapping from BufferSize-1 to 0, including for non-power-of-two sizes.
REQ-016 SHALL increment R_Addr on each Pop, with the same wrap rule as W_Addr.
REQ-017 SHALL keep an internal Round bit: set on a Push at W_Addr=BufferSize-1, cleared on a Pop at R_Addr=BufferSize-1; if both happen in one cycle, the bit is set.
REQ-018 SHALL compute Full = Round & (W_Addr==R_Addr) and Empty = ~Round & (W_Addr==R_Addr) from registered state only, with no combinational path from the request inputs.
REQ-019 SHALL update Count by +1 on Push only, -1 on Pop only, and leave it unchanged on both or neither; Count always equals the pointer distance.
REQ-020 SHALL, when Full and both requests are present, accept only Pop; the Push becomes legal the next cycle.
REQ-021 SHALL, when Empty and both requests are present, accept only Push (no fall-through); Pop becomes legal the next cycle.
REQ-022 SHALL assert AlmostFull as a registered flag when Count >= AlmostFullLevel, updated in the same edge as Count.
REQ-023 SHALL set Overflow on a cycle with Push_Req & clk_en & Full, and hold it until reset.
REQ-024 SHALL set Underflow on a cycle with Pop_Req & clk_en & Empty, and hold it until reset.
REQ-025 SHALL hold every register when clk_en=0, regardless of requests.

Reset
REQ-026 SHALL, with aclr high at a rising edge, clear W_Addr, R_Addr, Round, Count, AlmostFull, Overflow and Underflow to 0, giving Empty=1 and Full=0.
REQ-027 SHALL give aclr priority over clk_en and over all requests, including in the middle of a burst.
REQ-028 SHALL keep Push and Pop low while aclr is high.

Structure
REQ-029 SHALL place no typedefs in a shared package; parameters only, passed from the top level.
REQ-030 SHALL use one sub-module, fifo_ptr_cnt (a wrapping pointer counter with increment enable and a last-address indicator), instantiated twice for the write and read pointers.
REQ-031 SHALL keep the Round, Count and flag logic in the top module.

Verification (BufferSize=16, AlmostFullLevel=12)
REQ-032 SHALL test: reset, then 16 Push_Req cycles -> W_Addr wraps 15->0, Full=1 and Count=16 after the 16th edge, AlmostFull=1 from Count=12.
REQ-033 SHALL test: a 17th Push_Req while Full -> Push=0, W_Addr unchanged, Overflow=1 and sticky.
REQ-034 SHALL test: Push_Req and Pop_Req together while Full -> only Pop=1, Count=15, Full=0 the next cycle.
REQ-035 SHALL test: Pop_Req on Empty after reset -> Pop=0, Underflow=1; Push and Pop together while Empty -> Count=1.
REQ-036 SHALL test: clk_en=0 with both requests for 5 cycles -> all outputs constant, Push=Pop=0.
REQ-037 SHALL test: aclr pulsed at Count=9 during simultaneous traffic -> all state 0 and Empty=1 on the next edge.
